// File: rtl/spi_engine_offload_mc.sv
// Multi-channel SPI Engine offload: per-channel command/SDO programs
// replayed on trigger, channels served round-robin, SDI tagged by channel.
module spi_engine_offload_mc #(
   parameter int NUM_OFFLOAD           = 2,
   parameter int CMD_MEM_ADDRESS_WIDTH = 4,
   parameter int SDO_MEM_ADDRESS_WIDTH = 4,
   parameter int DATA_WIDTH            = 8,
   parameter int NUM_OF_SDI            = 1
) (
   input  logic                               spi_clk,
   input  logic                               spi_reset,
   input  logic [NUM_OFFLOAD-1:0]             ctrl_enable,
   output logic [NUM_OFFLOAD-1:0]             ctrl_enabled,
   input  logic [NUM_OFFLOAD-1:0]             ctrl_mem_reset,
   output logic [NUM_OFFLOAD-1:0]             ctrl_overrun,
   input  logic                               ctrl_cmd_wr_en,
   input  logic [((NUM_OFFLOAD>1)?$clog2(NUM_OFFLOAD):1)-1:0] ctrl_cmd_wr_chan,
   input  logic [15:0]                        ctrl_cmd_wr_data,
   input  logic                               ctrl_sdo_wr_en,
   input  logic [((NUM_OFFLOAD>1)?$clog2(NUM_OFFLOAD):1)-1:0] ctrl_sdo_wr_chan,
   input  logic [DATA_WIDTH-1:0]              ctrl_sdo_wr_data,
   input  logic [NUM_OFFLOAD-1:0]             trigger,
   output logic                               cmd_valid,
   input  logic                               cmd_ready,
   output logic [15:0]                        cmd_data,
   output logic                               sdo_data_valid,
   input  logic                               sdo_data_ready,
   output logic [DATA_WIDTH-1:0]              sdo_data,
   input  logic                               sdi_data_valid,
   output logic                               sdi_data_ready,
   input  logic [NUM_OF_SDI*DATA_WIDTH-1:0]   sdi_data,
   output logic                               offload_sdi_valid,
   input  logic                               offload_sdi_ready,
   output logic [NUM_OF_SDI*DATA_WIDTH-1:0]   offload_sdi_data,
   output logic [((NUM_OFFLOAD>1)?$clog2(NUM_OFFLOAD):1)-1:0] offload_sdi_chan,
   input  logic                               sync_valid,
   output logic                               sync_ready,
   input  logic [7:0]                         sync_data,
   output logic                               busy,
   output logic [((NUM_OFFLOAD>1)?$clog2(NUM_OFFLOAD):1)-1:0] active_chan
);

   localparam int CHAN_W = (NUM_OFFLOAD > 1) ? $clog2(NUM_OFFLOAD) : 1;
   localparam int CW     = CMD_MEM_ADDRESS_WIDTH;
   localparam int SW     = SDO_MEM_ADDRESS_WIDTH;
   localparam int CDEPTH = 1 << CW;
   localparam int SDEPTH = 1 << SW;

   typedef enum logic [1:0] {
      S_IDLE, S_LOAD, S_RUN, S_WAIT
   } state_t;

   logic [15:0]            cmd_mem [NUM_OFFLOAD][CDEPTH];
   logic [DATA_WIDTH-1:0]  sdo_mem [NUM_OFFLOAD][SDEPTH];

   logic [CW:0]            cmd_len_q [NUM_OFFLOAD];
   logic [CW:0]            cmd_len_d [NUM_OFFLOAD];
   logic [SW:0]            sdo_len_q [NUM_OFFLOAD];
   logic [SW:0]            sdo_len_d [NUM_OFFLOAD];

   logic [NUM_OFFLOAD-1:0] pending_q, pending_d;
   logic [NUM_OFFLOAD-1:0] overrun_q, overrun_d;
   logic [NUM_OFFLOAD-1:0] trig_q, trig_edge;
   logic [NUM_OFFLOAD-1:0] chan_act, mreset_ok, drop;
   logic [NUM_OFFLOAD-1:0] cmd_we, sdo_we;

   state_t                 state_q;
   logic [CHAN_W-1:0]      active_q, last_q, sel, rr_idx;
   logic                   sel_vld, take;
   logic [CW-1:0]          cmd_idx_q;
   logic [15:0]            cmd_data_q;
   logic                   cmd_valid_q, busy_q;
   logic                   cmd_last;
   logic [SW-1:0]          sdo_ptr_q, sdo_ptr_nxt;
   logic [SW:0]            sdo_len_a;
   logic                   sdo_vld;
   logic                   unused_sync;

   assign trig_edge = trigger & ~trig_q;

   // "active" covers LOAD too so a program is never edited under the reader
   always_comb begin
      chan_act  = '0;
      mreset_ok = '0;
      cmd_we    = '0;
      sdo_we    = '0;
      for (int k = 0; k < NUM_OFFLOAD; k++) begin
         chan_act[k]  = (state_q != S_IDLE) && (active_q == CHAN_W'(k));
         mreset_ok[k] = ctrl_mem_reset[k] && !chan_act[k];
         cmd_we[k]    = ctrl_cmd_wr_en && (ctrl_cmd_wr_chan == CHAN_W'(k))
                        && (cmd_len_q[k] != (CW+1)'(CDEPTH)) && !chan_act[k];
         sdo_we[k]    = ctrl_sdo_wr_en && (ctrl_sdo_wr_chan == CHAN_W'(k))
                        && (sdo_len_q[k] != (SW+1)'(SDEPTH)) && !chan_act[k];
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_OFFLOAD; k++) begin
         cmd_len_d[k] = cmd_len_q[k];
         sdo_len_d[k] = sdo_len_q[k];
         if (mreset_ok[k]) begin
            cmd_len_d[k] = '0;
            sdo_len_d[k] = '0;
         end else begin
            if (cmd_we[k]) cmd_len_d[k] = cmd_len_q[k] + (CW+1)'(1);
            if (sdo_we[k]) sdo_len_d[k] = sdo_len_q[k] + (SW+1)'(1);
         end
      end
   end

   always_comb begin
      sel     = '0;
      sel_vld = 1'b0;
      rr_idx  = '0;
      for (int i = 1; i <= NUM_OFFLOAD; i++) begin
         rr_idx = CHAN_W'((int'(last_q) + i) % NUM_OFFLOAD);
         if (!sel_vld && pending_q[rr_idx]) begin
            sel_vld = 1'b1;
            sel     = rr_idx;
         end
      end
   end

   assign take = (state_q == S_IDLE) && sel_vld;

   // post-write length gates the trigger so a same-cycle write counts
   always_comb begin
      pending_d = pending_q;
      overrun_d = overrun_q;
      drop      = '0;
      for (int k = 0; k < NUM_OFFLOAD; k++) begin
         drop[k] = trig_edge[k] && (pending_q[k] || chan_act[k]);
         if (take && sel == CHAN_W'(k)) pending_d[k] = 1'b0;
         if (trig_edge[k] && !drop[k] && ctrl_enable[k]
             && cmd_len_d[k] != '0)
            pending_d[k] = 1'b1;
         if (!ctrl_enable[k] || mreset_ok[k]) pending_d[k] = 1'b0;
         if (mreset_ok[k]) overrun_d[k] = 1'b0;
         if (drop[k]) overrun_d[k] = 1'b1;
      end
   end

   assign cmd_last = ({1'b0, cmd_idx_q}
                      == cmd_len_q[active_q] - (CW+1)'(1));
   assign sdo_len_a = sdo_len_q[active_q];
   assign sdo_vld   = busy_q && (sdo_len_a != '0);
   assign sdo_ptr_nxt = (({1'b0, sdo_ptr_q} + (SW+1)'(1)) == sdo_len_a)
                        ? '0 : sdo_ptr_q + SW'(1);

   always_ff @(posedge spi_clk) begin
      for (int k = 0; k < NUM_OFFLOAD; k++) begin
         if (cmd_we[k]) cmd_mem[k][cmd_len_q[k][CW-1:0]] <= ctrl_cmd_wr_data;
         if (sdo_we[k]) sdo_mem[k][sdo_len_q[k][SW-1:0]] <= ctrl_sdo_wr_data;
      end
   end

   always_ff @(posedge spi_clk) begin
      if (spi_reset) begin
         state_q     <= S_IDLE;
         active_q    <= '0;
         last_q      <= CHAN_W'(NUM_OFFLOAD - 1);
         cmd_idx_q   <= '0;
         cmd_data_q  <= '0;
         cmd_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         sdo_ptr_q   <= '0;
         trig_q      <= '0;
         pending_q   <= '0;
         overrun_q   <= '0;
         for (int k = 0; k < NUM_OFFLOAD; k++) begin
            cmd_len_q[k] <= '0;
            sdo_len_q[k] <= '0;
         end
      end else begin
         trig_q    <= trigger;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         cmd_len_q <= cmd_len_d;
         sdo_len_q <= sdo_len_d;
         if (sdo_vld && sdo_data_ready) sdo_ptr_q <= sdo_ptr_nxt;
         unique case (state_q)
            S_IDLE: begin
               if (take) begin
                  active_q <= sel;
                  state_q  <= S_LOAD;
               end
            end
            S_LOAD: begin
               cmd_idx_q  <= '0;
               cmd_data_q <= cmd_mem[active_q][0];
               // program may have been wiped after it was queued
               if (cmd_len_q[active_q] != '0) begin
                  state_q     <= S_RUN;
                  cmd_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               if (cmd_ready) begin
                  if (cmd_last) begin
                     cmd_valid_q <= 1'b0;
                     state_q     <= S_WAIT;
                  end else begin
                     cmd_idx_q  <= cmd_idx_q + CW'(1);
                     cmd_data_q <= cmd_mem[active_q][cmd_idx_q + CW'(1)];
                  end
               end
            end
            S_WAIT: begin
               if (sync_valid) begin
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
                  sdo_ptr_q <= '0;
                  last_q    <= active_q;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      ctrl_enabled = ctrl_enable;
      for (int k = 0; k < NUM_OFFLOAD; k++)
         if (busy_q && active_q == CHAN_W'(k)) ctrl_enabled[k] = 1'b1;
   end

   assign ctrl_overrun      = overrun_q;
   assign cmd_valid         = cmd_valid_q;
   assign cmd_data          = cmd_data_q;
   assign sdo_data_valid    = sdo_vld;
   assign sdo_data          = sdo_vld ? sdo_mem[active_q][sdo_ptr_q] : '0;
   assign offload_sdi_valid = sdi_data_valid;
   assign sdi_data_ready    = offload_sdi_ready;
   assign offload_sdi_data  = sdi_data;
   assign offload_sdi_chan  = active_q;
   assign sync_ready        = 1'b1;
   assign busy              = busy_q;
   assign active_chan       = active_q;
   assign unused_sync       = ^sync_data;

endmodule

// File: tb/tb_spi_engine_offload_mc.sv
// Scoreboard bench for spi_engine_offload_mc: command, SDO and
// tagged SDI streams checked against queues filled at stimulus time.
module tb_spi_engine_offload_mc;

   localparam int N = 2;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        spi_reset;
   logic [1:0]  ctrl_enable, ctrl_enabled, ctrl_mem_reset, ctrl_overrun;
   logic        ctrl_cmd_wr_en, ctrl_sdo_wr_en;
   logic [0:0]  ctrl_cmd_wr_chan, ctrl_sdo_wr_chan;
   logic [15:0] ctrl_cmd_wr_data;
   logic [7:0]  ctrl_sdo_wr_data;
   logic [1:0]  trigger;
   logic        cmd_valid, cmd_ready;
   logic [15:0] cmd_data;
   logic        sdo_data_valid, sdo_data_ready;
   logic [7:0]  sdo_data;
   logic        sdi_data_valid, sdi_data_ready;
   logic [7:0]  sdi_data;
   logic        offload_sdi_valid, offload_sdi_ready;
   logic [7:0]  offload_sdi_data;
   logic [0:0]  offload_sdi_chan;
   logic        sync_valid, sync_ready;
   logic [7:0]  sync_data;
   logic        busy;
   logic [0:0]  active_chan;

   spi_engine_offload_mc dut (
      .spi_clk(clk), .spi_reset(spi_reset),
      .ctrl_enable(ctrl_enable), .ctrl_enabled(ctrl_enabled),
      .ctrl_mem_reset(ctrl_mem_reset), .ctrl_overrun(ctrl_overrun),
      .ctrl_cmd_wr_en(ctrl_cmd_wr_en), .ctrl_cmd_wr_chan(ctrl_cmd_wr_chan),
      .ctrl_cmd_wr_data(ctrl_cmd_wr_data),
      .ctrl_sdo_wr_en(ctrl_sdo_wr_en), .ctrl_sdo_wr_chan(ctrl_sdo_wr_chan),
      .ctrl_sdo_wr_data(ctrl_sdo_wr_data),
      .trigger(trigger),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .sdo_data_valid(sdo_data_valid), .sdo_data_ready(sdo_data_ready),
      .sdo_data(sdo_data),
      .sdi_data_valid(sdi_data_valid), .sdi_data_ready(sdi_data_ready),
      .sdi_data(sdi_data),
      .offload_sdi_valid(offload_sdi_valid),
      .offload_sdi_ready(offload_sdi_ready),
      .offload_sdi_data(offload_sdi_data),
      .offload_sdi_chan(offload_sdi_chan),
      .sync_valid(sync_valid), .sync_ready(sync_ready),
      .sync_data(sync_data),
      .busy(busy), .active_chan(active_chan)
   );

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [16:0] cmd_q [$];
   logic [7:0]  sdo_q [$];
   logic [8:0]  sdi_q [$];

   logic [15:0] mcmd [N][16];
   int          mclen [N];
   logic [7:0]  msdo [N][16];
   int          mslen [N];

   logic        rnd_en = 1'b0;
   logic        hold_v = 1'b0;
   logic [15:0] hold_d = '0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (hold_v && cmd_valid) check("cmd_hold", cmd_data, hold_d);
      hold_v = cmd_valid && !cmd_ready;
      hold_d = cmd_data;
      if (cmd_valid && cmd_ready) begin
         if (cmd_q.size() == 0) check("cmd_extra", cmd_q.size(), 1);
         else check("cmd", {active_chan, cmd_data}, cmd_q.pop_front());
      end
      if (sdo_data_valid && sdo_data_ready) begin
         if (sdo_q.size() == 0) check("sdo_extra", sdo_q.size(), 1);
         else check("sdo", sdo_data, sdo_q.pop_front());
      end
      if (offload_sdi_valid && offload_sdi_ready) begin
         if (sdi_q.size() == 0) check("sdi_extra", sdi_q.size(), 1);
         else check("sdi", {offload_sdi_chan, offload_sdi_data},
                    sdi_q.pop_front());
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rnd_en) cmd_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_cmd(input int ch, input logic [15:0] d);
      if (mclen[ch] < 16) begin
         mcmd[ch][mclen[ch]] = d;
         mclen[ch]++;
      end
      ctrl_cmd_wr_en = 1'b1; ctrl_cmd_wr_chan = 1'(ch);
      ctrl_cmd_wr_data = d;
      tick();
      ctrl_cmd_wr_en = 1'b0;
   endtask

   task automatic wr_sdo(input int ch, input logic [7:0] d);
      if (mslen[ch] < 16) begin
         msdo[ch][mslen[ch]] = d;
         mslen[ch]++;
      end
      ctrl_sdo_wr_en = 1'b1; ctrl_sdo_wr_chan = 1'(ch);
      ctrl_sdo_wr_data = d;
      tick();
      ctrl_sdo_wr_en = 1'b0;
   endtask

   task automatic mem_rst(input int ch);
      ctrl_mem_reset = 2'(1 << ch);
      tick();
      ctrl_mem_reset = '0;
      mclen[ch] = 0;
      mslen[ch] = 0;
   endtask

   task automatic trig(input logic [1:0] m);
      trigger = m;
      tick();
      trigger = '0;
   endtask

   task automatic push_cmds(input int ch);
      for (int i = 0; i < mclen[ch]; i++)
         cmd_q.push_back({1'(ch), mcmd[ch][i]});
   endtask

   task automatic sdo_burst(input int ch, input int n);
      for (int i = 0; i < n; i++) sdo_q.push_back(msdo[ch][i % mslen[ch]]);
      sdo_data_ready = 1'b1;
      repeat (n) tick();
      sdo_data_ready = 1'b0;
   endtask

   task automatic sdi_pulse(input int ch, input logic [7:0] d);
      sdi_q.push_back({1'(ch), d});
      sdi_data_valid = 1'b1; sdi_data = d;
      tick();
      sdi_data_valid = 1'b0;
   endtask

   task automatic wait_wsync(input string tag);
      int n = 0;
      while (!(busy && !cmd_valid) && n < 400) begin
         tick();
         n++;
      end
      check(tag, busy && !cmd_valid, 1);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!cmd_valid && n < 50) begin
         tick();
         n++;
      end
      check(tag, cmd_valid, 1);
   endtask

   task automatic do_sync();
      sync_valid = 1'b1; sync_data = 8'h5A;
      tick();
      sync_valid = 1'b0;
      check("sync_busy", busy, 0);
   endtask

   initial begin
      spi_reset = 1'b1; ctrl_enable = '0; ctrl_mem_reset = '0;
      ctrl_cmd_wr_en = 0; ctrl_cmd_wr_chan = '0; ctrl_cmd_wr_data = '0;
      ctrl_sdo_wr_en = 0; ctrl_sdo_wr_chan = '0; ctrl_sdo_wr_data = '0;
      trigger = '0; cmd_ready = 0; sdo_data_ready = 0;
      sdi_data_valid = 0; sdi_data = '0; offload_sdi_ready = 1;
      sync_valid = 0; sync_data = '0;
      for (int k = 0; k < N; k++) begin
         mclen[k] = 0;
         mslen[k] = 0;
      end
      repeat (3) tick();
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_sync_ready", sync_ready, 1);
      check("rst_enabled", ctrl_enabled, 0);
      check("rst_overrun", ctrl_overrun, 0);
      check("rst_sdo_valid", sdo_data_valid, 0);
      check("rst_active", active_chan, 0);
      spi_reset = 1'b0;
      tick();

      // joint triggers: ch0 first from reset, then ch1, then ch0 again
      wr_cmd(0, 16'h2001); wr_cmd(0, 16'h2002);
      wr_cmd(1, 16'h3001); wr_cmd(1, 16'h3002);
      ctrl_enable = 2'b11; cmd_ready = 1'b1;
      for (int r = 0; r < 2; r++) begin
         push_cmds(0); push_cmds(1);
         trig(2'b11);
         wait_wsync("rr_wsync0");
         check("rr_chan0", active_chan, 0);
         sdi_pulse(0, 8'h40 + 8'(r));
         do_sync();
         wait_wsync("rr_wsync1");
         check("rr_chan1", active_chan, 1);
         sdi_pulse(1, 8'h50 + 8'(r));
         do_sync();
      end

      // single channel program with timing and SDO repeat
      mem_rst(0);
      check("mrst_overrun", ctrl_overrun, 0);
      wr_cmd(0, 16'h1001); wr_cmd(0, 16'h1002); wr_cmd(0, 16'h1003);
      wr_sdo(0, 8'hA5);
      push_cmds(0);
      trig(2'b01);
      tick(); check("t2_valid", cmd_valid, 0);
      tick(); check("t3_valid", cmd_valid, 1);
      check("t3_data", cmd_data, 16'h1001);
      check("t3_busy", busy, 1);
      wait_wsync("t1_wsync");
      sdo_burst(0, 3);
      sdi_pulse(0, 8'h5C);
      do_sync();

      // retrigger during RUN, then memory reset and write+trigger
      cmd_ready = 1'b0;
      push_cmds(1);
      trig(2'b10);
      wait_valid("ovr_valid");
      check("ovr_active", active_chan, 1);
      trig(2'b10);
      check("ovr_set", ctrl_overrun, 2'b10);
      cmd_ready = 1'b1;
      wait_wsync("ovr_wsync");
      do_sync();
      repeat (5) tick();
      check("ovr_no_rerun", busy, 0);
      mem_rst(1);
      check("ovr_clear", ctrl_overrun, 0);
      trig(2'b10);
      repeat (5) tick();
      check("empty_trig_busy", busy, 0);
      check("empty_trig_ovr", ctrl_overrun, 0);
      mcmd[1][0] = 16'h5001; mclen[1] = 1;
      push_cmds(1);
      ctrl_cmd_wr_en = 1'b1; ctrl_cmd_wr_chan = 1'b1;
      ctrl_cmd_wr_data = 16'h5001; trigger = 2'b10;
      tick();
      ctrl_cmd_wr_en = 1'b0; trigger = '0;
      wait_wsync("wrtrig_wsync");
      do_sync();

      // random backpressure, write to active channel, SDO wrap
      mem_rst(0);
      for (int i = 0; i < 5; i++) wr_cmd(0, 16'h6000 + 16'(i));
      wr_sdo(0, 8'h10); wr_sdo(0, 8'h11); wr_sdo(0, 8'h12);
      push_cmds(0);
      rnd_en = 1'b1;
      trig(2'b01);
      wait_valid("rnd_valid");
      ctrl_cmd_wr_en = 1'b1; ctrl_cmd_wr_chan = 1'b0;
      ctrl_cmd_wr_data = 16'hBEEF;
      tick();
      ctrl_cmd_wr_en = 1'b0;
      wait_wsync("rnd_wsync");
      rnd_en = 1'b0;
      tick();
      cmd_ready = 1'b1;
      sdo_burst(0, 7);
      do_sync();

      // full command memory: 17th write dropped
      mem_rst(0);
      for (int i = 0; i < 17; i++) wr_cmd(0, 16'h4000 + 16'(i));
      push_cmds(0);
      trig(2'b01);
      wait_wsync("full_wsync");
      do_sync();

      // disable while running, then reset mid-RUN
      cmd_ready = 1'b0;
      trig(2'b01);
      wait_valid("rst_run_valid");
      ctrl_enable = 2'b00;
      #1;
      check("finish_enabled", ctrl_enabled, 2'b01);
      spi_reset = 1'b1;
      tick();
      check("mid_rst_valid", cmd_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_enabled", ctrl_enabled, 0);
      check("mid_rst_sync_ready", sync_ready, 1);
      spi_reset = 1'b0;
      repeat (3) tick();

      check("cmd_q_left", cmd_q.size(), 0);
      check("sdo_q_left", sdo_q.size(), 0);
      check("sdi_q_left", sdi_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vec_cnt, err_cnt);
      $finish;
   end

endmodule
